// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with data-memory handshake
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rd,
    input  logic [4:0]        ifid_rs1,
    input  logic [4:0]        ifid_rs2,
    input  logic              branch_taken,
    input  logic              exmem_mem_read,
    input  logic              exmem_mem_write,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_mem_err;
    logic [PERF_W-1:0]  r_stall_cycles;

    logic w_mem_op;
    logic w_lu_hazard;
    logic w_timeout;
    logic w_mem_stall;

    assign w_mem_op    = exmem_mem_read | exmem_mem_write;
    assign w_lu_hazard = idex_mem_read && (idex_rd != 5'd0) &&
                         ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    assign w_timeout   = (r_state == ST_WAIT) && !dmem_ready &&
                         (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));
    // A timeout releases the pipeline exactly as a ready would.
    assign w_mem_stall = (r_state == ST_IDLE) ? (w_mem_op && !dmem_ready)
                                              : (!dmem_ready && !w_timeout);

    always_comb begin
        dmem_req    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            dmem_req = (r_state == ST_WAIT) ? 1'b1 : w_mem_op;
            if (w_mem_stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_lu_hazard) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op && !dmem_ready) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        r_wait_cnt <= '0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
            if (!pc_en && (r_stall_cycles != {PERF_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        branch_taken;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic        dmem_ready;
    logic        dmem_req;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        mem_err;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    // {dmem_req, pc/ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush}
    localparam logic [9:0] C_DEF = 10'b0_11111_0000;
    localparam logic [9:0] C_RST = 10'b0_00000_1111;
    localparam logic [9:0] C_LU  = 10'b0_00111_0100;
    localparam logic [9:0] C_BR  = 10'b0_11111_1100;
    localparam logic [9:0] C_MST = 10'b1_00001_0001;
    localparam logic [9:0] C_REL = 10'b1_11111_0000;
    localparam logic [9:0] C_RBR = 10'b1_11111_1100;

    logic [9:0] w_ctrl;
    assign w_ctrl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .branch_taken(branch_taken),
        .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the combinational outputs for the current inputs, then advance one clock.
    task automatic cyc(input string tag, input logic [9:0] exp);
        #1;
        check(tag, 32'(w_ctrl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        idex_mem_read   = 1'b0;
        idex_rd         = 5'd0;
        ifid_rs1        = 5'd0;
        ifid_rs2        = 5'd0;
        branch_taken    = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_ctrl", C_RST);
        rst = 1'b0;
        check("reset_stall", stall_cycles, 32'd0);
        check("reset_err", 32'(mem_err), 32'd0);
        cyc("idle_default", C_DEF);

        // load-use on rs1, then rs2, then rd=0 never hazards
        idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd7;
        cyc("lu_rs1", C_LU);
        exp_stall++;
        check("lu_stall_cnt", stall_cycles, 32'(exp_stall));
        ifid_rs1 = 5'd1; ifid_rs2 = 5'd5;
        cyc("lu_rs2", C_LU);
        exp_stall++;
        idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
        cyc("lu_rd0", C_DEF);
        check("lu_rd0_cnt", stall_cycles, 32'(exp_stall));
        idle_inputs();

        // load with 3 wait cycles
        exmem_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("ld_wait%0d", i), C_MST);
            exp_stall++;
        end
        dmem_ready = 1'b1;
        cyc("ld_release", C_REL);
        idle_inputs();
        cyc("ld_after", C_DEF);
        check("ld_stall_cnt", stall_cycles, 32'(exp_stall));
        check("ld_err", 32'(mem_err), 32'd0);

        // zero-wait store, then a back-to-back zero-wait store from IDLE
        exmem_mem_write = 1'b1; dmem_ready = 1'b1;
        cyc("st_zero_wait", C_REL);
        cyc("st_back2back", C_REL);
        idle_inputs();
        cyc("st_after", C_DEF);
        check("st_stall_cnt", stall_cycles, 32'(exp_stall));

        // branch beats load-use; branch ignored during memory stall
        branch_taken = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rs2 = 5'd9;
        cyc("br_over_lu", C_BR);
        check("br_stall_cnt", stall_cycles, 32'(exp_stall));
        idle_inputs();
        exmem_mem_read = 1'b1;
        cyc("br_mem_idle", C_MST);
        exp_stall++;
        branch_taken = 1'b1;
        cyc("br_in_wait", C_MST);
        exp_stall++;
        dmem_ready = 1'b1;
        cyc("br_at_release", C_RBR);
        idle_inputs();
        check("br_wait_cnt", stall_cycles, 32'(exp_stall));

        // timeout after 4 stall cycles, sticky error
        exmem_mem_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("to_wait%0d", i), C_MST);
            exp_stall++;
        end
        cyc("to_abort", C_REL);
        check("to_err_set", 32'(mem_err), 32'd1);
        check("to_stall_cnt", stall_cycles, 32'(exp_stall));
        idle_inputs();
        cyc("to_after", C_DEF);
        cyc("to_after2", C_DEF);
        check("to_err_sticky", 32'(mem_err), 32'd1);

        // reset while waiting
        exmem_mem_read = 1'b1;
        cyc("rw_idle", C_MST);
        cyc("rw_wait1", C_MST);
        rst = 1'b1;
        cyc("rw_reset", C_RST);
        rst = 1'b0;
        idle_inputs();
        check("rw_stall_clr", stall_cycles, 32'd0);
        check("rw_err_clr", 32'(mem_err), 32'd0);
        cyc("rw_default", C_DEF);
        exmem_mem_read = 1'b1; dmem_ready = 1'b1;
        cyc("rw_fresh_op", C_REL);
        check("rw_no_stall", stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
